// File: rtl/avmm_ccip_burst_splitter.sv
// Avalon-MM burst splitter placed in front of the CCI-P host bridge.
// Re-issues arbitrary line bursts as naturally aligned 1/2/4-line sub-bursts.
module avmm_ccip_burst_splitter #(
   parameter int DATA_WIDTH  = 512,
   parameter int ADDR_WIDTH  = 49,
   parameter int BURST_WIDTH = 7
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_WIDTH-1:0]   s_address,
   input  logic [BURST_WIDTH-1:0]  s_burstcount,
   input  logic                    s_read,
   input  logic                    s_write,
   input  logic [DATA_WIDTH-1:0]   s_writedata,
   input  logic [DATA_WIDTH/8-1:0] s_byteenable,
   output logic                    s_waitrequest,
   output logic [DATA_WIDTH-1:0]   s_readdata,
   output logic                    s_readdatavalid,
   output logic [ADDR_WIDTH-1:0]   m_address,
   output logic [2:0]              m_burstcount,
   output logic                    m_read,
   output logic                    m_write,
   output logic [DATA_WIDTH-1:0]   m_writedata,
   output logic [DATA_WIDTH/8-1:0] m_byteenable,
   input  logic                    m_waitrequest,
   input  logic [DATA_WIDTH-1:0]   m_readdata,
   input  logic                    m_readdatavalid,
   output logic                    busy
);

   localparam int LINE_W = ADDR_WIDTH - 7;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;

   logic [1:0]             state;
   logic [LINE_W-1:0]      line_q;
   logic [BURST_WIDTH-1:0] rem_q;
   logic [2:0]             n_q;
   logic [2:0]             left_q;
   logic                   fence_q;

   logic [LINE_W-1:0]      s_line;
   logic [BURST_WIDTH-1:0] s_cnt;
   logic                   unused_low_addr;

   logic [LINE_W-1:0]      cur_line;
   logic [BURST_WIDTH-1:0] cur_rem;
   logic [2:0]             cur_n;
   logic [2:0]             cur_left;
   logic                   cur_fence;

   logic                   accept;
   logic                   adv;
   logic [2:0]             step;
   logic [BURST_WIDTH-1:0] nxt_rem;
   logic [LINE_W-1:0]      nxt_line;
   logic [2:0]             nxt_n;
   logic [2:0]             nxt_left;
   logic                   nxt_fence;

   // Largest of 4/2/1 lines that fits the remainder and is naturally aligned.
   function automatic logic [2:0] sub_size(input logic [LINE_W-1:0] line,
                                           input logic [BURST_WIDTH-1:0] rem);
      if (rem >= BURST_WIDTH'(4) && line[1:0] == 2'b00)
         return 3'd4;
      else if (rem >= BURST_WIDTH'(2) && !line[0])
         return 3'd2;
      else
         return 3'd1;
   endfunction

   assign s_line          = s_address[ADDR_WIDTH-2:6];
   assign s_cnt           = (s_burstcount == '0) ? BURST_WIDTH'(1) : s_burstcount;
   assign unused_low_addr = ^s_address[5:0];

   // In IDLE the current sub-burst comes straight from the slave inputs so the
   // first command goes out with no added latency; otherwise from the registers.
   always_comb begin
      cur_line  = s_line;
      cur_rem   = s_cnt;
      cur_n     = sub_size(s_line, s_cnt);
      cur_left  = cur_n;
      cur_fence = s_read ? 1'b0 : s_address[ADDR_WIDTH-1];
      case (state)
         RD: begin
            cur_line  = line_q;
            cur_rem   = rem_q;
            cur_n     = sub_size(line_q, rem_q);
            cur_left  = cur_n;
            cur_fence = 1'b0;
         end
         WR: begin
            cur_line  = line_q;
            cur_rem   = rem_q;
            cur_n     = n_q;
            cur_left  = left_q;
            cur_fence = fence_q;
         end
         default: ;
      endcase
   end

   assign m_read        = reset_n & (((state == IDLE) & s_read) | (state == RD));
   assign m_write       = reset_n & ((state == IDLE) | (state == WR)) & s_write;
   assign s_waitrequest = ~reset_n | (state == RD) | m_waitrequest;
   assign m_address     = {cur_fence, cur_line, 6'b0};
   assign m_burstcount  = cur_n;
   assign m_writedata   = s_writedata;
   assign m_byteenable  = s_byteenable;
   assign s_readdata      = m_readdata;
   assign s_readdatavalid = m_readdatavalid;
   assign busy          = (state == RD) | (state == WR);

   // A read command retires a whole sub-burst; a write beat retires one line and
   // moves to the next sub-burst only after the last beat of the current one.
   assign accept    = (m_read | m_write) & ~m_waitrequest;
   assign step      = m_read ? cur_n : 3'd1;
   assign nxt_rem   = cur_rem - BURST_WIDTH'(step);
   assign adv       = m_read | (cur_left == 3'd1);
   assign nxt_line  = adv ? cur_line + LINE_W'(cur_n) : cur_line;
   assign nxt_n     = adv ? sub_size(nxt_line, nxt_rem) : cur_n;
   assign nxt_left  = adv ? nxt_n : cur_left - 3'd1;
   assign nxt_fence = adv ? 1'b0 : cur_fence;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         line_q  <= '0;
         rem_q   <= '0;
         n_q     <= 3'd1;
         left_q  <= 3'd1;
         fence_q <= 1'b0;
      end else if (accept) begin
         if (nxt_rem == '0)
            state <= IDLE;
         else
            state <= m_read ? RD : WR;
         line_q  <= nxt_line;
         rem_q   <= nxt_rem;
         n_q     <= nxt_n;
         left_q  <= nxt_left;
         fence_q <= nxt_fence;
      end
   end

endmodule

// File: tb/tb_avmm_ccip_burst_splitter.sv
// Directed bench for avmm_ccip_burst_splitter: records every accepted master
// command/beat and returned read beat, then compares against hand-built lists.
module tb_avmm_ccip_burst_splitter;

   localparam int DW = 512;
   localparam int AW = 49;
   localparam int BW = 7;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [AW-1:0]   s_address = '0;
   logic [BW-1:0]   s_burstcount = '0;
   logic            s_read = 1'b0;
   logic            s_write = 1'b0;
   logic [DW-1:0]   s_writedata = '0;
   logic [DW/8-1:0] s_byteenable = '1;
   logic            s_waitrequest;
   logic [DW-1:0]   s_readdata;
   logic            s_readdatavalid;
   logic [AW-1:0]   m_address;
   logic [2:0]      m_burstcount;
   logic            m_read;
   logic            m_write;
   logic [DW-1:0]   m_writedata;
   logic [DW/8-1:0] m_byteenable;
   logic            m_waitrequest = 1'b0;
   logic [DW-1:0]   m_readdata = '0;
   logic            m_readdatavalid = 1'b0;
   logic            busy;

   int num_compared = 0;
   int num_mismatched = 0;
   int wait_cycles = 0;
   logic rand_wait = 1'b0;

   logic [63:0] mon_addr[$];
   logic [63:0] mon_bc[$];
   logic [63:0] mon_data[$];
   logic [63:0] rdv_data[$];
   logic [63:0] exp_addr[$];
   logic [63:0] exp_bc[$];
   logic [63:0] exp_rdv[$];
   logic [41:0] ret_q[$];

   avmm_ccip_burst_splitter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_address(s_address), .s_burstcount(s_burstcount),
      .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid),
      .m_address(m_address), .m_burstcount(m_burstcount),
      .m_read(m_read), .m_write(m_write),
      .m_writedata(m_writedata), .m_byteenable(m_byteenable),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid), .busy(busy)
   );

   always #5 clk = ~clk;

   // Observe the master side mid-cycle, when everything has settled.
   always @(negedge clk) begin
      if (reset_n) begin
         if (s_waitrequest) wait_cycles++;
         if ((m_read || m_write) && !m_waitrequest) begin
            mon_addr.push_back(64'(m_address));
            mon_bc.push_back(64'(m_burstcount));
            if (m_write) mon_data.push_back(m_writedata[63:0]);
            if (m_read)
               for (int j = 0; j < int'(m_burstcount); j++)
                  ret_q.push_back(m_address[47:6] + 42'(j));
         end
         if (s_readdatavalid) rdv_data.push_back(s_readdata[63:0]);
      end
   end

   // Host bridge stand-in: returns each requested line (data = line address) in order.
   always @(posedge clk) begin
      #1;
      m_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ret_q.size() > 0) begin
         m_readdatavalid = 1'b1;
         m_readdata      = DW'(ret_q.pop_front());
      end else begin
         m_readdatavalid = 1'b0;
         m_readdata      = '0;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
      num_compared++;
      if (got !== expv) begin
         num_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_sub(input logic fence, input logic [41:0] line, input int n, input int reps);
      for (int r = 0; r < reps; r++) begin
         exp_addr.push_back(64'({fence, line, 6'b0}));
         exp_bc.push_back(64'(n));
      end
   endtask

   task automatic compareCmds(input string tag);
      checkOutput({tag, "_count"}, 64'(mon_addr.size()), 64'(exp_addr.size()));
      for (int i = 0; i < mon_addr.size() && i < exp_addr.size(); i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), mon_addr[i], exp_addr[i]);
         checkOutput($sformatf("%s_bc%0d", tag, i), mon_bc[i], exp_bc[i]);
      end
      mon_addr.delete(); mon_bc.delete(); exp_addr.delete(); exp_bc.delete();
   endtask

   task automatic compareData(input string tag, input int n);
      checkOutput({tag, "_beats"}, 64'(mon_data.size()), 64'(n));
      for (int i = 0; i < mon_data.size() && i < n; i++)
         checkOutput($sformatf("%s_data%0d", tag, i), mon_data[i], 64'hD000 + 64'(i));
      mon_data.delete();
   endtask

   task automatic compareRdv(input string tag);
      checkOutput({tag, "_rdv_count"}, 64'(rdv_data.size()), 64'(exp_rdv.size()));
      for (int i = 0; i < rdv_data.size() && i < exp_rdv.size(); i++)
         checkOutput($sformatf("%s_rdv%0d", tag, i), rdv_data[i], exp_rdv[i]);
      rdv_data.delete(); exp_rdv.delete();
   endtask

   // Drive one slave burst (one read command, or every write beat), then drain.
   task automatic applyStimulus(input logic is_write, input logic [AW-1:0] addr,
                                input logic [BW-1:0] bc, input logic gaps);
      int beats;
      int guard;
      logic acc;
      beats = is_write ? ((bc == '0) ? 1 : int'(bc)) : 1;
      s_address    = addr;
      s_burstcount = bc;
      for (int i = 0; i < beats; i++) begin
         if (gaps && (i % 3 == 1)) begin
            s_write = 1'b0;
            tick();
         end
         s_read      = !is_write;
         s_write     = is_write;
         s_writedata = DW'(64'hD000 + 64'(i));
         guard = 0;
         acc   = 1'b0;
         while (!acc && guard < 200) begin
            @(negedge clk);
            acc = !s_waitrequest;
            tick();
            guard++;
         end
         if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
      end
      s_read  = 1'b0;
      s_write = 1'b0;
      guard = 0;
      @(negedge clk);
      while ((busy || ret_q.size() > 0 || m_readdatavalid) && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 400) checkOutput("drain_timeout", 64'd0, 64'd1);
      repeat (2) @(negedge clk);
      tick();
   endtask

   initial begin
      int w0;
      repeat (3) @(negedge clk);
      checkOutput("rst_m_read", 64'(m_read), 64'd0);
      checkOutput("rst_m_write", 64'(m_write), 64'd0);
      checkOutput("rst_waitreq", 64'(s_waitrequest), 64'd1);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Read line 0x3, burst 7, junk in the byte-offset bits.
      w0 = wait_cycles;
      applyStimulus(1'b0, {1'b0, 42'h3, 6'h15}, 7'd7, 1'b0);
      checkOutput("rd7_wait", 64'(wait_cycles - w0), 64'd2);
      add_sub(1'b0, 42'h3, 1, 1);
      add_sub(1'b0, 42'h4, 4, 1);
      add_sub(1'b0, 42'h8, 2, 1);
      compareCmds("rd7");
      for (int i = 3; i <= 9; i++) exp_rdv.push_back(64'(i));
      compareRdv("rd7");

      // Write line 0x2, burst 6.
      applyStimulus(1'b1, {1'b0, 42'h2, 6'h0}, 7'd6, 1'b0);
      add_sub(1'b0, 42'h2, 2, 2);
      add_sub(1'b0, 42'h4, 4, 4);
      compareCmds("wr6");
      compareData("wr6", 6);

      // Fenced write: only the first sub-burst carries bit 48.
      applyStimulus(1'b1, {1'b1, 42'h0, 6'h0}, 7'd8, 1'b0);
      add_sub(1'b1, 42'h0, 4, 4);
      add_sub(1'b0, 42'h4, 4, 4);
      compareCmds("wr8f");
      compareData("wr8f", 8);

      // 64-line write at line 0x1 under random backpressure and write gaps.
      rand_wait = 1'b1;
      applyStimulus(1'b1, {1'b0, 42'h1, 6'h0}, 7'd64, 1'b1);
      rand_wait = 1'b0;
      add_sub(1'b0, 42'h1, 1, 1);
      add_sub(1'b0, 42'h2, 2, 2);
      for (int k = 0; k < 15; k++) add_sub(1'b0, 42'(4 + 4 * k), 4, 4);
      add_sub(1'b0, 42'd64, 1, 1);
      compareCmds("wr64");
      compareData("wr64", 64);

      // Line-address wrap on a read; the fence bit must never reach a read.
      applyStimulus(1'b0, {1'b1, 42'h3FF_FFFF_FFFF, 6'h0}, 7'd3, 1'b0);
      add_sub(1'b0, 42'h3FF_FFFF_FFFF, 1, 1);
      add_sub(1'b0, 42'h0, 2, 1);
      compareCmds("wrap");
      exp_rdv.push_back(64'h3FF_FFFF_FFFF);
      exp_rdv.push_back(64'h0);
      exp_rdv.push_back(64'h1);
      compareRdv("wrap");

      // Burstcount 0 behaves as a single line.
      applyStimulus(1'b0, {1'b0, 42'h6, 6'h0}, 7'd0, 1'b0);
      add_sub(1'b0, 42'h6, 1, 1);
      compareCmds("bc0");
      exp_rdv.push_back(64'h6);
      compareRdv("bc0");

      // Reset in the middle of a write burst.
      s_address    = {1'b0, 42'h0, 6'h0};
      s_burstcount = 7'd4;
      s_write      = 1'b1;
      tick();
      tick();
      checkOutput("midwr_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("midwr_rst_m_write", 64'(m_write), 64'd0);
      checkOutput("midwr_rst_waitreq", 64'(s_waitrequest), 64'd1);
      checkOutput("midwr_rst_busy", 64'(busy), 64'd0);
      s_write = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      mon_addr.delete(); mon_bc.delete(); mon_data.delete();
      applyStimulus(1'b1, {1'b0, 42'h5, 6'h0}, 7'd1, 1'b0);
      add_sub(1'b0, 42'h5, 1, 1);
      compareCmds("post_rst");
      compareData("post_rst", 1);
      checkOutput("post_rst_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule

// File: doc/avmm_ccip_burst_splitter.md
# avmm_ccip_burst_splitter

Avalon-MM burst adapter placed directly upstream of the CCI-P host bridge (`avmm_ccip_host`). It accepts arbitrary-length, line-granular Avalon read and write bursts. It re-issues each burst as a sequence of CCI-P-legal sub-bursts of 1, 2 or 4 cache lines, each naturally aligned. Read data passes back unmodified, because the host bridge returns lines in order.

## Interface
- DATA_WIDTH, 512: data bus width; one beat = one 64 B line.
- ADDR_WIDTH, 49: byte address width. Bit 48 is the write-fence flag; bits 47:6 are the line address.
- BURST_WIDTH, 7: slave burstcount width; maximum burst is 64 lines.
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- s_address  in  ADDR_WIDTH  slave byte address; bits 5:0 ignored
- s_burstcount  in  BURST_WIDTH  slave burst length in lines
- s_read / s_write  in  1  slave commands; never asserted together
- s_writedata  in  DATA_WIDTH  write beat
- s_byteenable  in  DATA_WIDTH/8  passed through
- s_waitrequest  out  1  slave backpressure
- s_readdata  out  DATA_WIDTH  = m_readdata, combinational
- s_readdatavalid  out  1  = m_readdatavalid, combinational
- m_address  out  ADDR_WIDTH  sub-burst base address; bits 5:0 = 0
- m_burstcount  out  3  sub-burst length; only 1, 2 or 4
- m_read / m_write  out  1  master commands
- m_writedata / m_byteenable  out  DATA_WIDTH, DATA_WIDTH/8  passed through
- m_waitrequest  in  1  from host bridge
- m_readdata / m_readdatavalid  in  DATA_WIDTH, 1  from host bridge
- busy  out  1  high in states RD and WR

## Operation
- Sub-burst size rule, for line address L and remaining lines R: choose the largest n in {4, 2, 1} with n ≤ R and L mod n = 0.
- s_burstcount = 0 is treated as 1.
- Line-address arithmetic wraps modulo 2^42. Bits 47:6 advance; bit 48 is never carried into.
- State machine IDLE / RD / WR; all registers asynchronously reset to IDLE.
- IDLE, read:
  - m_read = s_read; m_address / m_burstcount are computed combinationally from s_address and s_burstcount; s_waitrequest = m_waitrequest.
  - On accept (m_read & ~m_waitrequest): if R − n > 0, register the next line address and R − n, then go to RD. Otherwise stay in IDLE.
- RD:
  - s_waitrequest = 1; m_read = 1 from registers.
  - Each accepted command advances the line address by n and decrements R by n.
  - Last sub-read accepted → IDLE.
- IDLE, write:
  - m_write = s_write; the first sub-burst is computed from the live inputs; s_waitrequest = m_waitrequest.
  - On accept: if the total burst is 1, stay in IDLE. Otherwise register the sub-burst base, beats left in the sub-burst, and total remaining, then go to WR.
- WR:
  - m_write = s_write; data and byteenable pass through; s_waitrequest = m_waitrequest.
  - m_address / m_burstcount are held constant for every beat of one sub-burst.
  - When a sub-burst's last beat is accepted, compute the next sub-burst from its base + n and the remaining count.
  - Total burst's last beat accepted → IDLE.
  - An s_write gap mid-burst is legal: the state holds and m_write = 0.
- Fence bit 48:
  - Reads: m_address[48] = 0 always.
  - Writes: bit 48 = s_address[48] only on the first sub-burst of a write burst; it is 0 on all later sub-bursts.
- Read data is never buffered; the total number of returned beats equals the original s_burstcount.

## Timing
- Zero added latency: the first sub-command appears in the same cycle as the slave command. Each further sub-command takes at least 1 cycle.
- A read burst split into k sub-reads holds s_waitrequest for at least k−1 extra cycles.
- Reset values while reset_n = 0: m_read = 0, m_write = 0, s_waitrequest = 1, busy = 0, state IDLE.
- Reset asserted mid-burst: the burst is abandoned immediately and the outputs take their reset values. The upstream master is reset together with this block.
- m_waitrequest must be honoured every cycle. While it is high, the outputs stay stable (the Avalon hold rule).

## Test plan
- Read at line 0x3, burst 7 → sub-reads (line 0x3, 1), (0x4, 4), (0x8, 2); s_waitrequest high for exactly 2 cycles with no backpressure; 7 readdatavalid beats returned in order.
- Write at line 0x2, burst 6, contiguous data D0–D5 → sub-bursts (0x2, 2), (0x4, 4); address and burstcount constant within each sub-burst; data order preserved.
- Write at line 0x0 with bit 48 set, burst 8 → (0x0, 4) with bit 48 = 1, then (0x4, 4) with bit 48 = 0.
- Random m_waitrequest (50%) plus s_write gaps on a 64-line burst at line 0x1 → no beat lost or duplicated; split is 1, 2, 4 × 15, 1.
- Wrap: read at line 0x3FF_FFFF_FFFF, burst 3 → (0x3FF_FFFF_FFFF, 1), (0x0, 2).
- reset_n pulsed low mid-WR → m_write = 0 and s_waitrequest = 1 at once; after release, a fresh burst of 1 completes in IDLE.
